usart_receiver: RTL and testbench
=================================

// Module: usart_receiver
// PURPOSE
//   UART receive stage paired with the my_usart transmitter: recovers 8N1 frames from rx_pin.
//   Frame format is 1 start bit, DATA_BITS data bits LSB first, no parity, 1 stop bit.
//   Delivers each received byte through a one-entry holding register with a valid/ready handshake.
//   Flags framing errors and overruns. Sits between the board RX pin and the consuming logic.
// PARAMETERS
//   DATA_BITS    8   data bits per frame (LSB first)
//   SYNC_STAGES  2   flip-flops in the rx_pin metastability synchroniser (>=2)
// PORTS
//   clock        in   1          system clock; all logic on posedge
//   reset        in   1          synchronous, active-high reset
//   prescaler    in   16         clock cycles per bit period; values <4 are treated as 4
//   rx_pin       in   1          asynchronous serial input, idle high
//   data_out     out  DATA_BITS  received byte; stable while data_valid=1
//   data_valid   out  1          holding register full
//   data_ready   in   1          consumer accepts data_out when data_valid && data_ready
//   frame_error  out  1          1-cycle pulse: stop bit sampled low
//   overrun      out  1          1-cycle pulse: frame completed while holding register full
//   rx_busy      out  1          1 from start-bit detect until return to IDLE
// BEHAVIOUR
//   Reset (synchronous, active-high):
//   - Outputs: data_out=0, data_valid=0, frame_error=0, overrun=0, rx_busy=0.
//   - State=IDLE; synchroniser preset to 1; reset mid-frame abandons the frame with no flags.
//   - After reset, wait for the synchronised line to be high before start detection.
//   Synchroniser: rx_pin passes through SYNC_STAGES flops to give rx_s.
//   - Edge detect uses rx_s and its one-cycle-delayed copy.
//   Prescaler latch: on start detect, latch P=max(prescaler,4) into a 16-bit register.
//   - Changes to prescaler mid-frame have no effect.
//   - Bit counter is 16 bits and compares for == P-1; it never wraps.
//   FSM:
//   - IDLE: wait for falling edge on rx_s. Then latch P, clear counter, rx_busy=1, go to START.
//   - START: after P>>1 cycles, sample rx_s.
//     - If 0: go to DATA with the bit index cleared.
//     - If 1 (glitch): go to IDLE, rx_busy=0, no flags.
//   - DATA: every P cycles, sample rx_s into shift register MSB; shift right.
//     - After DATA_BITS samples, go to STOP.
//   - STOP: after P cycles, sample rx_s.
//     - If 1: frame good; go to IDLE.
//     - If 0: frame_error pulses for 1 cycle and the byte is discarded; go to BREAK.
//   - BREAK: wait until rx_s=1, then go to IDLE. rx_busy=1 throughout BREAK.
//   Delivery (frame good, in the cycle after the stop sample):
//   - If data_valid=0, or data_ready=1 in that same cycle: load data_out, data_valid=1.
//     A simultaneous accept and load leaves data_valid at 1 with the new byte.
//   - Else: old byte kept, new byte dropped, overrun pulses for 1 cycle.
//   - Handshake: data_valid && data_ready clears data_valid next cycle unless a reload occurs.
//   Latency: falling edge on rx_pin to data_valid is
//     SYNC_STAGES + (P>>1) + (DATA_BITS+1)*P + 2 cycles, +/-1.
//   Back-to-back frames: a start edge is accepted in the first IDLE cycle after STOP.
// TESTING
//   - P=16; send 0xA5 as a clean 8N1 frame; data_ready=0.
//     -> data_valid=1, data_out=0xA5, frame_error=0, rx_busy=0 after the frame.
//   - P=16; drive rx_pin low for 5 cycles, then high.
//     -> START rejects the glitch; rx_busy returns to 0; no data_valid, no flags.
//   - P=16; send 0x3C with the stop bit forced low, then hold the line low for 40 cycles, then high.
//     -> frame_error pulses once; data_valid stays 0; FSM waits in BREAK; next frame 0x81 is received correctly.
//   - data_ready=0; send 0x11 then 0x22.
//     -> overrun pulses once at the end of the second frame; data_out stays 0x11.
//     -> Assert data_ready for 1 cycle -> data_valid=0.
//   - data_ready=1; send 0x00, 0xFF, 0x55 back-to-back at P=4.
//     -> three single-cycle data_valid pulses, in order; no overrun.
//   - Assert reset at bit 4 of a frame, release it while the line is still low, then send 0x7E.
//     -> all outputs 0; the partial frame is discarded; 0x7E is received.

Source files
------------

// File: rtl/usart_receiver.sv
// usart_receiver: 8N1 serial receive stage for the my_usart link.
// Synchronises rx_pin, times each bit from a latched prescaler, assembles
// the data bits LSB first and hands the byte to the consumer through a
// one-entry holding register with a valid/ready handshake.
module usart_receiver #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [15:0]          prescaler,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   armed;
    logic                   start_edge;

    logic [2:0]             state;
    logic [15:0]            p_reg;
    logic [15:0]            bit_cnt;
    logic [15:0]            p_eff;
    logic [15:0]            half_m1;
    logic [15:0]            p_m1;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   deliver_q;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    // A start is only believed once the real (not preset) line has been seen high.
    assign start_edge = armed & rx_prev & ~rx_s;
    assign p_eff      = (prescaler < 16'd4) ? 16'd4 : prescaler;
    assign half_m1    = (p_reg >> 1) - 16'd1;
    assign p_m1       = p_reg - 16'd1;
    assign rx_busy    = (state != S_IDLE);

    // Input conditioning: synchroniser chain, delayed copy for edge detect, and arming after reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '1;
            fill_q  <= '0;
            rx_prev <= 1'b1;
            armed   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_pin};
            fill_q  <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            rx_prev <= rx_s;
            if (fill_q[SYNC_STAGES] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame sequencer: bit timing, data sampling, stop check and break wait
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            p_reg       <= 16'd4;
            bit_cnt     <= 16'd0;
            bit_idx     <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            deliver_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        p_reg   <= p_eff;
                        bit_cnt <= 16'd0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_cnt == half_m1) begin
                        bit_cnt <= 16'd0;
                        if (!rx_s) begin
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == p_m1) begin
                        bit_cnt <= 16'd0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt == p_m1) begin
                        bit_cnt <= 16'd0;
                        if (rx_s) begin
                            deliver_q <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Holding register: load a good byte, or flag overrun if the consumer has not taken the last one
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver_q) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift_q;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usart_receiver.sv
// tb_usart_receiver: directed and randomised frames against usart_receiver.
// Serial frames are generated from the bit-period arithmetic of 8N1; the
// bench keeps its own queue of bytes it expects to be delivered.
module tb_usart_receiver;

    logic        clock;
    logic        reset;
    logic [15:0] prescaler;
    logic        rx_pin;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        frame_error;
    logic        overrun;
    logic        rx_busy;

    int assertions;
    int failures;
    int fe_count;
    int ov_count;
    int dv_cycles;
    logic [7:0] captured[$];
    logic [7:0] expected_q[$];

    usart_receiver #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .prescaler  (prescaler),
        .rx_pin     (rx_pin),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_error(frame_error),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Observe pulses and handshakes away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_error) fe_count++;
            if (overrun) ov_count++;
            if (data_valid) dv_cycles++;
            if (data_valid && data_ready) captured.push_back(data_out);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One 8N1 frame: start, 8 data bits LSB first, stop; prescaler may be changed after the start bit
    task automatic applyStimulus(input logic [7:0] data, input int p_bits, input logic [15:0] pre_after,
                                 input logic stop_level);
        rx_pin = 1'b0;
        waitCycles(p_bits);
        prescaler = pre_after;
        for (int i = 0; i < 8; i++) begin
            rx_pin = data[i];
            waitCycles(p_bits);
        end
        rx_pin = stop_level;
        waitCycles(p_bits);
    endtask

    task automatic acceptOne(input string tag, input logic [7:0] exp_byte);
        captured.delete();
        data_ready = 1'b1;
        waitCycles(1);
        data_ready = 1'b0;
        checkOutput({tag, "_valid_cleared"}, data_valid, 0);
        checkOutput({tag, "_capture_count"}, captured.size(), 1);
        if (captured.size() > 0) checkOutput({tag, "_capture_byte"}, captured[0], exp_byte);
        captured.delete();
    endtask

    initial begin
        int fe_base;
        int ov_base;
        int dv_base;
        assertions = 0;
        failures   = 0;
        fe_count   = 0;
        ov_count   = 0;
        dv_cycles  = 0;
        reset      = 1'b1;
        rx_pin     = 1'b1;
        prescaler  = 16'd16;
        data_ready = 1'b0;
        waitCycles(4);

        $display("[TB] reset state");
        checkOutput("reset_data_out", data_out, 0);
        checkOutput("reset_data_valid", data_valid, 0);
        checkOutput("reset_frame_error", frame_error, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_rx_busy", rx_busy, 0);
        reset = 1'b0;
        waitCycles(10);

        $display("[TB] clean frame 0xA5 at P=16");
        applyStimulus(8'hA5, 16, 16'd16, 1'b1);
        waitCycles(10);
        checkOutput("a5_valid", data_valid, 1);
        checkOutput("a5_data", data_out, 8'hA5);
        checkOutput("a5_no_fe", fe_count, 0);
        checkOutput("a5_idle", rx_busy, 0);
        acceptOne("a5", 8'hA5);

        $display("[TB] start glitch");
        rx_pin = 1'b0;
        waitCycles(5);
        checkOutput("glitch_busy", rx_busy, 1);
        rx_pin = 1'b1;
        waitCycles(40);
        checkOutput("glitch_idle", rx_busy, 0);
        checkOutput("glitch_no_valid", data_valid, 0);
        checkOutput("glitch_no_fe", fe_count, 0);
        checkOutput("glitch_no_ov", ov_count, 0);

        $display("[TB] framing error and break");
        applyStimulus(8'h3C, 16, 16'd16, 1'b0);
        waitCycles(40);
        checkOutput("break_busy", rx_busy, 1);
        checkOutput("break_fe_once", fe_count, 1);
        checkOutput("break_no_valid", data_valid, 0);
        rx_pin = 1'b1;
        waitCycles(10);
        checkOutput("break_exit", rx_busy, 0);
        applyStimulus(8'h81, 16, 16'd16, 1'b1);
        waitCycles(10);
        checkOutput("after_break_valid", data_valid, 1);
        checkOutput("after_break_data", data_out, 8'h81);
        checkOutput("after_break_fe", fe_count, 1);
        acceptOne("b81", 8'h81);

        $display("[TB] overrun");
        ov_base = ov_count;
        applyStimulus(8'h11, 16, 16'd16, 1'b1);
        waitCycles(5);
        applyStimulus(8'h22, 16, 16'd16, 1'b1);
        waitCycles(10);
        checkOutput("overrun_once", ov_count - ov_base, 1);
        checkOutput("overrun_keep_valid", data_valid, 1);
        checkOutput("overrun_keep_data", data_out, 8'h11);
        acceptOne("ov11", 8'h11);

        $display("[TB] back-to-back at P=4 with data_ready held");
        captured.delete();
        ov_base    = ov_count;
        dv_base    = dv_cycles;
        prescaler  = 16'd4;
        data_ready = 1'b1;
        applyStimulus(8'h00, 4, 16'd4, 1'b1);
        applyStimulus(8'hFF, 4, 16'd4, 1'b1);
        applyStimulus(8'h55, 4, 16'd4, 1'b1);
        waitCycles(10);
        checkOutput("b2b_count", captured.size(), 3);
        checkOutput("b2b_valid_cycles", dv_cycles - dv_base, 3);
        checkOutput("b2b_no_ov", ov_count - ov_base, 0);
        if (captured.size() == 3) begin
            checkOutput("b2b_byte0", captured[0], 8'h00);
            checkOutput("b2b_byte1", captured[1], 8'hFF);
            checkOutput("b2b_byte2", captured[2], 8'h55);
        end
        data_ready = 1'b0;
        captured.delete();

        $display("[TB] reset mid-frame");
        prescaler = 16'd16;
        fe_base   = fe_count;
        applyStimulus(8'h42, 16, 16'd16, 1'b1);
        waitCycles(10);
        checkOutput("prereset_valid", data_valid, 1);
        rx_pin = 1'b0;
        waitCycles(16);
        for (int i = 0; i < 4; i++) begin
            rx_pin = 1'b1;
            waitCycles(16);
        end
        rx_pin = 1'b0;
        waitCycles(4);
        reset = 1'b1;
        waitCycles(2);
        checkOutput("midreset_data_out", data_out, 0);
        checkOutput("midreset_valid", data_valid, 0);
        checkOutput("midreset_fe", frame_error, 0);
        checkOutput("midreset_ov", overrun, 0);
        checkOutput("midreset_busy", rx_busy, 0);
        reset = 1'b0;
        waitCycles(20);
        checkOutput("postreset_low_idle", rx_busy, 0);
        rx_pin = 1'b1;
        waitCycles(20);
        checkOutput("postreset_high_idle", rx_busy, 0);
        checkOutput("postreset_no_valid", data_valid, 0);
        applyStimulus(8'h7E, 16, 16'd16, 1'b1);
        waitCycles(10);
        checkOutput("b7e_valid", data_valid, 1);
        checkOutput("b7e_data", data_out, 8'h7E);
        checkOutput("b7e_no_fe", fe_count - fe_base, 0);
        acceptOne("b7e", 8'h7E);

        $display("[TB] randomised frames");
        captured.delete();
        expected_q.delete();
        fe_base    = fe_count;
        ov_base    = ov_count;
        data_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            int          pval;
            int          eff;
            logic [7:0]  b;
            logic [15:0] other;
            pval      = $urandom_range(0, 24);
            eff       = (pval < 4) ? 4 : pval;
            b         = 8'($urandom);
            other     = 16'($urandom_range(0, 40));
            prescaler = 16'(pval);
            applyStimulus(b, eff, other, 1'b1);
            expected_q.push_back(b);
            waitCycles($urandom_range(0, 4));
        end
        waitCycles(60);
        checkOutput("rand_count", captured.size(), expected_q.size());
        for (int i = 0; i < expected_q.size(); i++) begin
            if (i < captured.size()) checkOutput($sformatf("rand_byte%0d", i), captured[i], expected_q[i]);
        end
        checkOutput("rand_no_fe", fe_count - fe_base, 0);
        checkOutput("rand_no_ov", ov_count - ov_base, 0);
        data_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
